// File: rtl/sliding_tile_move_sched.sv
// rtl/sliding_tile_move_sched.sv - two-port move arbiter, FIFO and legality checker for the 3x3 tile datapath
module sliding_tile_move_sched #(
   parameter int         DEPTH       = 4,
   parameter int         CNT_W       = 8,
   parameter logic [3:0] RESET_SPACE = 4'b1010
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_val,
   input  logic [1:0]       req0_dir,
   output logic             req0_rdy,
   input  logic             req1_val,
   input  logic [1:0]       req1_dir,
   output logic             req1_rdy,
   input  logic             pause,
   input  logic             solved,
   output logic             mv_en,
   output logic [1:0]       mv_dir,
   output logic [3:0]       space_loc,
   output logic [CNT_W-1:0] move_count,
   output logic             reject,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

   typedef enum logic {RUN, SOLVED} state_t;

   state_t        state;
   logic [1:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic          rr;

   logic          open;
   logic          grant0;
   logic          grant1;
   logic          push;
   logic [1:0]    push_dir;
   logic          pop;
   logic [1:0]    head;
   logic          legal;
   logic [3:0]    next_loc;
   logic [1:0]    row;
   logic [1:0]    col;

   // Arbitration: one accept per cycle, round-robin only when both requesters contend
   always_comb begin
      open     = (state == RUN) && !solved && (fill < FULL_FILL);
      grant0   = req0_val && open && (!req1_val || !rr);
      grant1   = req1_val && open && (!req0_val || rr);
      push     = grant0 || grant1;
      push_dir = grant0 ? req0_dir : req1_dir;
      pop      = (state == RUN) && !solved && !pause && (fill != '0);
      req0_rdy = grant0;
      req1_rdy = grant1;
      busy     = (fill != '0);
   end

   // Legality of the head move against the shadow space position, and where the space goes
   always_comb begin
      head     = fifo_mem[rd_ptr];
      row      = space_loc[3:2];
      col      = space_loc[1:0];
      legal    = 1'b0;
      next_loc = space_loc;
      case (head)
         2'b00: begin legal = (col != 2'd0); next_loc = {row, col - 2'd1}; end
         2'b01: begin legal = (col <  2'd2); next_loc = {row, col + 2'd1}; end
         2'b10: begin legal = (row != 2'd0); next_loc = {row - 2'd1, col}; end
         default: begin legal = (row < 2'd2); next_loc = {row + 2'd1, col}; end
      endcase
   end

   // FIFO storage needs no reset; emptiness is tracked by fill
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_dir;
   end

   // Control state, FIFO pointers, issue strobes and the shadow space/move counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         rr         <= 1'b0;
         mv_en      <= 1'b0;
         mv_dir     <= 2'b00;
         reject     <= 1'b0;
         space_loc  <= RESET_SPACE;
         move_count <= '0;
      end else begin
         mv_en  <= 1'b0;
         reject <= 1'b0;
         if (state == RUN && solved) begin
            state  <= SOLVED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && req0_val && req1_val) rr <= ~rr;
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
               if (legal) begin
                  mv_en     <= 1'b1;
                  mv_dir    <= head;
                  space_loc <= next_loc;
                  if (move_count != '1) move_count <= move_count + CNT_W'(1);
               end else begin
                  reject <= 1'b1;
               end
            end
            if (push && !pop)      fill <= fill + 1'b1;
            else if (!push && pop) fill <= fill - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sliding_tile_move_sched.sv
// tb/tb_sliding_tile_move_sched.sv - directed self-checking bench for sliding_tile_move_sched
module tb_sliding_tile_move_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_val, req1_val;
   logic [1:0] req0_dir, req1_dir;
   logic       req0_rdy, req1_rdy;
   logic       pause, solved;
   logic       mv_en;
   logic [1:0] mv_dir;
   logic [3:0] space_loc;
   logic [7:0] move_count;
   logic       reject, busy;

   int n_cmp = 0;
   int n_err = 0;

   sliding_tile_move_sched #(.DEPTH(4), .CNT_W(8), .RESET_SPACE(4'b1010)) dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_dir(req0_dir), .req0_rdy(req0_rdy),
      .req1_val(req1_val), .req1_dir(req1_dir), .req1_rdy(req1_rdy),
      .pause(pause), .solved(solved),
      .mv_en(mv_en), .mv_dir(mv_dir), .space_loc(space_loc),
      .move_count(move_count), .reject(reject), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_issue(input string tag, input logic en, input logic [1:0] dir,
                            input logic [3:0] loc, input logic [7:0] cnt);
      chk({tag, "_en"},  32'(mv_en),      32'(en));
      if (en) chk({tag, "_dir"}, 32'(mv_dir), 32'(dir));
      chk({tag, "_loc"}, 32'(space_loc),  32'(loc));
      chk({tag, "_cnt"}, 32'(move_count), 32'(cnt));
   endtask

   initial begin
      reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0; req0_dir = 2'b00; req1_dir = 2'b00;
      pause = 1'b0; solved = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      chk_issue("rst", 1'b0, 2'b00, 4'b1010, 8'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_reject", 32'(reject), 32'd0);

      // RIGHT from bottom-right corner is illegal
      req0_val = 1'b1; req0_dir = 2'b01; settle();
      chk("acc_r_rdy0", 32'(req0_rdy), 32'd1);
      chk("acc_r_rdy1", 32'(req1_rdy), 32'd0);
      tick(); req0_val = 1'b0; settle();
      chk("acc_r_busy", 32'(busy), 32'd1);
      chk("acc_r_noen", 32'(mv_en), 32'd0);
      tick();
      chk("ill_reject", 32'(reject), 32'd1);
      chk_issue("ill", 1'b0, 2'b00, 4'b1010, 8'd0);
      chk("ill_busy", 32'(busy), 32'd0);
      tick();
      chk("ill_reject_clr", 32'(reject), 32'd0);

      // LEFT then UP back to back
      req0_val = 1'b1; req0_dir = 2'b00;
      tick(); req0_dir = 2'b10;
      tick(); req0_val = 1'b0; settle();
      chk_issue("left", 1'b1, 2'b00, 4'b1001, 8'd1);
      tick();
      chk_issue("up", 1'b1, 2'b10, 4'b0101, 8'd2);
      tick();
      chk("up_en_clr", 32'(mv_en), 32'd0);

      // contention: req0 UP vs req1 LEFT
      req0_val = 1'b1; req0_dir = 2'b10; req1_val = 1'b1; req1_dir = 2'b00; settle();
      chk("rr_first_rdy0", 32'(req0_rdy), 32'd1);
      chk("rr_first_rdy1", 32'(req1_rdy), 32'd0);
      tick();
      chk("rr_second_rdy0", 32'(req0_rdy), 32'd0);
      chk("rr_second_rdy1", 32'(req1_rdy), 32'd1);
      tick(); req0_val = 1'b0; req1_val = 1'b0; settle();
      chk_issue("rr_up", 1'b1, 2'b10, 4'b0001, 8'd3);
      tick();
      chk_issue("rr_left", 1'b1, 2'b00, 4'b0000, 8'd4);
      tick();

      // pause: fill to DEPTH with DOWN,UP,DOWN,UP
      pause = 1'b1; req0_val = 1'b1;
      req0_dir = 2'b11; settle(); chk("p_acc0", 32'(req0_rdy), 32'd1); tick();
      req0_dir = 2'b10; settle(); chk("p_acc1", 32'(req0_rdy), 32'd1); tick();
      req0_dir = 2'b11; settle(); chk("p_acc2", 32'(req0_rdy), 32'd1); tick();
      req0_dir = 2'b10; settle(); chk("p_acc3", 32'(req0_rdy), 32'd1); tick();
      chk("p_full_rdy", 32'(req0_rdy), 32'd0);
      chk("p_full_busy", 32'(busy), 32'd1);
      chk("p_noen", 32'(mv_en), 32'd0);
      req0_val = 1'b0; pause = 1'b0;
      tick(); chk_issue("p_dn0", 1'b1, 2'b11, 4'b0100, 8'd5);
      tick(); chk_issue("p_up0", 1'b1, 2'b10, 4'b0000, 8'd6);
      tick(); chk_issue("p_dn1", 1'b1, 2'b11, 4'b0100, 8'd7);
      tick(); chk_issue("p_up1", 1'b1, 2'b10, 4'b0000, 8'd8);
      chk("p_drained", 32'(busy), 32'd0);
      tick();
      chk("p_en_clr", 32'(mv_en), 32'd0);

      // solved with two moves queued
      pause = 1'b1; req0_val = 1'b1;
      req0_dir = 2'b01; tick();
      req0_dir = 2'b11; tick();
      req0_val = 1'b0; settle();
      chk("s_busy_pre", 32'(busy), 32'd1);
      solved = 1'b1; pause = 1'b0; req0_val = 1'b1; req1_val = 1'b1; settle();
      chk("s_comb_rdy0", 32'(req0_rdy), 32'd0);
      chk("s_comb_rdy1", 32'(req1_rdy), 32'd0);
      tick();
      chk("s_flush", 32'(busy), 32'd0);
      chk("s_reject", 32'(reject), 32'd0);
      chk_issue("s_frozen", 1'b0, 2'b00, 4'b0000, 8'd8);
      solved = 1'b0; settle();
      chk("s_hold_rdy0", 32'(req0_rdy), 32'd0);
      chk("s_hold_rdy1", 32'(req1_rdy), 32'd0);
      tick();
      chk_issue("s_hold", 1'b0, 2'b00, 4'b0000, 8'd8);

      // reset leaves SOLVED
      reset = 1'b1; tick(); reset = 1'b0; settle();
      chk_issue("rst2", 1'b0, 2'b00, 4'b1010, 8'd0);
      chk("rst2_rdy0", 32'(req0_rdy), 32'd1);
      chk("rst2_rdy1", 32'(req1_rdy), 32'd0);
      req0_val = 1'b0; req1_val = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
